vga_bouncing_box: RTL and testbench
===================================

// Module: vga_bouncing_box
// PURPOSE
//  Pixel-generation stage downstream of the VGA timing controller. Consumes its nextX/nextY,
//  blank and sync outputs. Drives 8-bit RGB to the video DAC, with sync/blank delayed to match.
//  Draws a filled square that bounces off the screen edges, plus a one-pixel screen border.
//  Box position updates once per frame, inside vertical sync, so the image never tears.
// PARAMETERS
//  H_DISPLAY  800  visible pixels per line
//  V_DISPLAY  600  visible lines per frame
//  BOX_SIZE   64   box side length, pixels
//  STEP       2    pixels moved per frame on each axis
//  BG_COLOUR  24'h000020  background {R,G,B}
//  BOX_COLOUR 24'hFFFFFF  box {R,G,B}; BORDER_COLOUR 24'hFF0000 border {R,G,B}
// PORTS
//  Clock       in   1   pixel clock
//  Reset_n     in   1   asynchronous reset, active low
//  Run         in   1   1 = box moves each frame, 0 = box frozen
//  nextX       in   11  pixel X from timing controller
//  nextY       in   10  pixel Y from timing controller
//  blank_n_in  in   1   1 = visible pixel
//  sync_n_in   in   1   composite sync from controller
//  hSync_n_in  in   1   horizontal sync, active low
//  vSync_n_in  in   1   vertical sync, active low
//  Red/Green/Blue out 8 each  pixel colour
//  blank_n, sync_n, hSync_n, vSync_n  out 1 each  inputs delayed by 2 clocks
//  BoxX        out  11  current box left edge
//  BoxY        out  10  current box top edge
//  FrameCount  out  16  vSync falling edges since reset; wraps at 65535 -> 0
// BEHAVIOUR
//  Reset (async, Reset_n=0), values take effect immediately:
//   - RGB=0; blank_n=0; sync_n=0; hSync_n=1; vSync_n=1.
//   - BoxX=0; BoxY=0; dirX=right; dirY=down; FrameCount=0.
//   - Pipeline registers cleared to these same values; vSync history register = 1.
//  Pipeline, fixed 2-clock latency for every output bit:
//   - S1 registers nextX, nextY, blank_n_in and the three sync inputs.
//   - S2 computes the colour from S1 and registers it with the delayed sync/blank.
//  Colour priority:
//   - blank=0 -> 0.
//   - else inside box (BoxX<=x<BoxX+BOX_SIZE and BoxY<=y<BoxY+BOX_SIZE) -> BOX_COLOUR.
//   - else border (x==0 | x==H_DISPLAY-1 | y==0 | y==V_DISPLAY-1) -> BORDER_COLOUR.
//   - else BG_COLOUR.
//  Frame tick:
//   - Asserted for one clock when vSync_n_in is 0 and the previous sample is 1.
//   - A long sync pulse gives exactly one tick.
//  On each tick:
//   - FrameCount += 1.
//   - If Run=1, each axis updates independently. X axis, MAXX=H_DISPLAY-BOX_SIZE:
//     - right and BoxX+STEP>=MAXX -> BoxX=MAXX, dir=left; else BoxX+=STEP.
//     - left and BoxX<=STEP -> BoxX=0, dir=right; else BoxX-=STEP.
//   - Y axis is identical, with MAXY=V_DISPLAY-BOX_SIZE and up/down.
//   - Run=0 -> position and direction hold; FrameCount still counts.
//  Width rules:
//   - Compare in 12-bit (X) and 11-bit (Y) to avoid overflow.
//   - Position never leaves 0..MAXX / 0..MAXY.
//  Ticks only occur in vertical blank; box registers are stable during visible lines.
//  Reset mid-frame: restart from reset state; first tick is at the next vSync falling edge.
// TESTING
//  T1 release reset, blank_n_in=1, nextX=0, nextY=0 for 2 clk -> RGB=FFFFFF (box beats border).
//  T2 hSync_n_in 1->0 at clk N, blank_n_in 0 at N -> hSync_n=0 and RGB=0 exactly at N+2.
//  T3 vSync_n_in held low 6 lines, Run=1 -> one tick: BoxX=2, BoxY=2, FrameCount=1.
//  T4 268 ticks -> BoxY=536, dirY=up; 368 ticks -> BoxX=736; tick 369 -> BoxX=734.
//  T5 Run=0, 10 ticks -> BoxX/BoxY unchanged; FrameCount+10. nextX=400, nextY=599 -> FF0000.
//  T6 Reset_n=0 mid-line, async -> outputs at reset values same clk, BoxX=BoxY=0.

Source files
------------

// File: rtl/vga_bouncing_box.sv
// Pixel stage behind the VGA timing controller: draws a bouncing filled square and a
// one-pixel screen border, with sync/blank delayed to match the two-clock colour pipeline.
module vga_bouncing_box #(
    parameter int          H_DISPLAY     = 800,
    parameter int          V_DISPLAY     = 600,
    parameter int          BOX_SIZE      = 64,
    parameter int          STEP          = 2,
    parameter logic [23:0] BG_COLOUR     = 24'h000020,
    parameter logic [23:0] BOX_COLOUR    = 24'hFFFFFF,
    parameter logic [23:0] BORDER_COLOUR = 24'hFF0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        run_i,
    input  logic [10:0] nextX_i,
    input  logic [9:0]  nextY_i,
    input  logic        blankN_i,
    input  logic        syncN_i,
    input  logic        hSyncN_i,
    input  logic        vSyncN_i,
    output logic [7:0]  red_o,
    output logic [7:0]  green_o,
    output logic [7:0]  blue_o,
    output logic        blankN_o,
    output logic        syncN_o,
    output logic        hSyncN_o,
    output logic        vSyncN_o,
    output logic [10:0] boxX_o,
    output logic [9:0]  boxY_o,
    output logic [15:0] frameCount_o
);

    localparam logic [11:0] MAX_X  = 12'(H_DISPLAY - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(V_DISPLAY - BOX_SIZE);
    localparam logic [11:0] STEP_X = 12'(STEP);
    localparam logic [10:0] STEP_Y = 11'(STEP);
    localparam logic [11:0] SIZE_X = 12'(BOX_SIZE);
    localparam logic [10:0] SIZE_Y = 11'(BOX_SIZE);
    localparam logic [10:0] LAST_X = 11'(H_DISPLAY - 1);
    localparam logic [9:0]  LAST_Y = 10'(V_DISPLAY - 1);

    logic [10:0] xS1_q;
    logic [9:0]  yS1_q;
    logic        blankS1_q, syncS1_q, hSyncS1_q, vSyncS1_q;

    logic [23:0] colour_q, colour_d;
    logic        blankS2_q, syncS2_q, hSyncS2_q, vSyncS2_q;

    logic [10:0] boxX_q, boxX_d;
    logic [9:0]  boxY_q, boxY_d;
    logic        dirXLeft_q, dirXLeft_d;
    logic        dirYUp_q, dirYUp_d;
    logic [15:0] frameCount_q;
    logic        vSyncPrev_q;
    logic        frameTick;

    logic inBoxX, inBoxY, onBorder;

    assign frameTick = vSyncPrev_q & ~vSyncN_i;

    // Box extent compared one bit wider so BoxX+BOX_SIZE cannot wrap.
    assign inBoxX = ({1'b0, xS1_q} >= {1'b0, boxX_q}) &&
                    ({1'b0, xS1_q} < ({1'b0, boxX_q} + SIZE_X));
    assign inBoxY = ({1'b0, yS1_q} >= {1'b0, boxY_q}) &&
                    ({1'b0, yS1_q} < ({1'b0, boxY_q} + SIZE_Y));
    assign onBorder = (xS1_q == 11'd0) || (xS1_q == LAST_X) ||
                      (yS1_q == 10'd0) || (yS1_q == LAST_Y);

    always_comb begin
        colour_d = BG_COLOUR;
        if (!blankS1_q)
            colour_d = 24'h000000;
        else if (inBoxX && inBoxY)
            colour_d = BOX_COLOUR;
        else if (onBorder)
            colour_d = BORDER_COLOUR;
    end

    always_comb begin
        boxX_d     = boxX_q;
        boxY_d     = boxY_q;
        dirXLeft_d = dirXLeft_q;
        dirYUp_d   = dirYUp_q;
        if (frameTick && run_i) begin
            if (!dirXLeft_q) begin
                if (({1'b0, boxX_q} + STEP_X) >= MAX_X) begin
                    boxX_d     = MAX_X[10:0];
                    dirXLeft_d = 1'b1;
                end else begin
                    boxX_d = boxX_q + STEP_X[10:0];
                end
            end else begin
                if ({1'b0, boxX_q} <= STEP_X) begin
                    boxX_d     = 11'd0;
                    dirXLeft_d = 1'b0;
                end else begin
                    boxX_d = boxX_q - STEP_X[10:0];
                end
            end
            if (!dirYUp_q) begin
                if (({1'b0, boxY_q} + STEP_Y) >= MAX_Y) begin
                    boxY_d   = MAX_Y[9:0];
                    dirYUp_d = 1'b1;
                end else begin
                    boxY_d = boxY_q + STEP_Y[9:0];
                end
            end else begin
                if ({1'b0, boxY_q} <= STEP_Y) begin
                    boxY_d   = 10'd0;
                    dirYUp_d = 1'b0;
                end else begin
                    boxY_d = boxY_q - STEP_Y[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            xS1_q        <= '0;
            yS1_q        <= '0;
            blankS1_q    <= 1'b0;
            syncS1_q     <= 1'b0;
            hSyncS1_q    <= 1'b1;
            vSyncS1_q    <= 1'b1;
            colour_q     <= '0;
            blankS2_q    <= 1'b0;
            syncS2_q     <= 1'b0;
            hSyncS2_q    <= 1'b1;
            vSyncS2_q    <= 1'b1;
            boxX_q       <= '0;
            boxY_q       <= '0;
            dirXLeft_q   <= 1'b0;
            dirYUp_q     <= 1'b0;
            frameCount_q <= '0;
            vSyncPrev_q  <= 1'b1;
        end else begin
            xS1_q        <= nextX_i;
            yS1_q        <= nextY_i;
            blankS1_q    <= blankN_i;
            syncS1_q     <= syncN_i;
            hSyncS1_q    <= hSyncN_i;
            vSyncS1_q    <= vSyncN_i;
            colour_q     <= colour_d;
            blankS2_q    <= blankS1_q;
            syncS2_q     <= syncS1_q;
            hSyncS2_q    <= hSyncS1_q;
            vSyncS2_q    <= vSyncS1_q;
            boxX_q       <= boxX_d;
            boxY_q       <= boxY_d;
            dirXLeft_q   <= dirXLeft_d;
            dirYUp_q     <= dirYUp_d;
            vSyncPrev_q  <= vSyncN_i;
            if (frameTick)
                frameCount_q <= frameCount_q + 16'd1;
        end
    end

    assign red_o        = colour_q[23:16];
    assign green_o      = colour_q[15:8];
    assign blue_o       = colour_q[7:0];
    assign blankN_o     = blankS2_q;
    assign syncN_o      = syncS2_q;
    assign hSyncN_o     = hSyncS2_q;
    assign vSyncN_o     = vSyncS2_q;
    assign boxX_o       = boxX_q;
    assign boxY_o       = boxY_q;
    assign frameCount_o = frameCount_q;

endmodule

// File: tb/tb_vga_bouncing_box.sv
// Directed bench for vga_bouncing_box: pipeline latency, colour priority, bounce and reset.
module tb_vga_bouncing_box;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        run_i;
    logic [10:0] nextX_i;
    logic [9:0]  nextY_i;
    logic        blankN_i, syncN_i, hSyncN_i, vSyncN_i;
    logic [7:0]  red_o, green_o, blue_o;
    logic        blankN_o, syncN_o, hSyncN_o, vSyncN_o;
    logic [10:0] boxX_o;
    logic [9:0]  boxY_o;
    logic [15:0] frameCount_o;

    int vectors = 0;
    int miscompares = 0;

    vga_bouncing_box dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i),
        .nextX_i(nextX_i), .nextY_i(nextY_i),
        .blankN_i(blankN_i), .syncN_i(syncN_i), .hSyncN_i(hSyncN_i), .vSyncN_i(vSyncN_i),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .blankN_o(blankN_o), .syncN_o(syncN_o), .hSyncN_o(hSyncN_o), .vSyncN_o(vSyncN_o),
        .boxX_o(boxX_o), .boxY_o(boxY_o), .frameCount_o(frameCount_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one pixel at a falling edge, then waits until it has crossed both stages.
    task automatic applyStimulus(input logic [10:0] x, input logic [9:0] y, input logic blank);
        @(negedge clk_i);
        nextX_i  = x;
        nextY_i  = y;
        blankN_i = blank;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic frameTicks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            vSyncN_i = 1'b0;
            @(negedge clk_i);
            vSyncN_i = 1'b1;
        end
    endtask

    initial begin
        rst_n_i  = 1'b0;
        run_i    = 1'b1;
        nextX_i  = '0;
        nextY_i  = '0;
        blankN_i = 1'b1;
        syncN_i  = 1'b1;
        hSyncN_i = 1'b1;
        vSyncN_i = 1'b1;
        repeat (3) @(negedge clk_i);

        checkOutput("rstRgb",   {red_o, green_o, blue_o}, 32'h0);
        checkOutput("rstBlank", blankN_o, 32'd0);
        checkOutput("rstSync",  syncN_o, 32'd0);
        checkOutput("rstHSync", hSyncN_o, 32'd1);
        checkOutput("rstVSync", vSyncN_o, 32'd1);
        checkOutput("rstBoxX",  boxX_o, 32'd0);
        checkOutput("rstFrames", frameCount_o, 32'd0);

        // T1: box at origin overrides the corner border pixel after exactly two clocks.
        rst_n_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t1Lat1", {red_o, green_o, blue_o}, 32'h0);
        @(negedge clk_i);
        checkOutput("t1Rgb",   {red_o, green_o, blue_o}, 32'hFFFFFF);
        checkOutput("t1Blank", blankN_o, 32'd1);

        // T2: hSync and blank both land at N+2.
        @(negedge clk_i);
        hSyncN_i = 1'b0;
        blankN_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t2HSyncEarly", hSyncN_o, 32'd1);
        @(negedge clk_i);
        checkOutput("t2HSync", hSyncN_o, 32'd0);
        checkOutput("t2Rgb",   {red_o, green_o, blue_o}, 32'h0);
        hSyncN_i = 1'b1;
        blankN_i = 1'b1;

        // T3: a long vSync pulse yields one tick.
        @(negedge clk_i);
        vSyncN_i = 1'b0;
        repeat (20) @(negedge clk_i);
        checkOutput("t3VSyncOut", vSyncN_o, 32'd0);
        vSyncN_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t3BoxX",   boxX_o, 32'd2);
        checkOutput("t3BoxY",   boxY_o, 32'd2);
        checkOutput("t3Frames", frameCount_o, 32'd1);

        // T4: Y hits its limit at tick 268, X at 368, both then reverse.
        frameTicks(267);
        checkOutput("t4BoxY268", boxY_o, 32'd536);
        checkOutput("t4BoxX268", boxX_o, 32'd536);
        frameTicks(1);
        checkOutput("t4BoxY269", boxY_o, 32'd534);
        checkOutput("t4BoxX269", boxX_o, 32'd538);
        frameTicks(99);
        checkOutput("t4BoxX368", boxX_o, 32'd736);
        checkOutput("t4BoxY368", boxY_o, 32'd336);
        frameTicks(1);
        checkOutput("t4BoxX369", boxX_o, 32'd734);
        checkOutput("t4BoxY369", boxY_o, 32'd334);
        checkOutput("t4Frames",  frameCount_o, 32'd369);

        // Box edges with the box at (734,334): spans x 734..797, y 334..397.
        applyStimulus(11'd734, 10'd334, 1'b1);
        checkOutput("edgeTopLeft", {red_o, green_o, blue_o}, 32'hFFFFFF);
        applyStimulus(11'd733, 10'd334, 1'b1);
        checkOutput("edgeLeftOut", {red_o, green_o, blue_o}, 32'h000020);
        applyStimulus(11'd797, 10'd397, 1'b1);
        checkOutput("edgeBotRight", {red_o, green_o, blue_o}, 32'hFFFFFF);
        applyStimulus(11'd798, 10'd397, 1'b1);
        checkOutput("edgeRightOut", {red_o, green_o, blue_o}, 32'h000020);
        applyStimulus(11'd797, 10'd398, 1'b1);
        checkOutput("edgeBotOut", {red_o, green_o, blue_o}, 32'h000020);
        applyStimulus(11'd799, 10'd300, 1'b1);
        checkOutput("borderRight", {red_o, green_o, blue_o}, 32'hFF0000);
        applyStimulus(11'd750, 10'd350, 1'b0);
        checkOutput("blankInBox", {red_o, green_o, blue_o}, 32'h0);

        // T5: frozen box, frame counter keeps running.
        run_i = 1'b0;
        frameTicks(10);
        checkOutput("t5BoxX",   boxX_o, 32'd734);
        checkOutput("t5BoxY",   boxY_o, 32'd334);
        checkOutput("t5Frames", frameCount_o, 32'd379);
        applyStimulus(11'd400, 10'd599, 1'b1);
        checkOutput("t5Border", {red_o, green_o, blue_o}, 32'hFF0000);

        // T6: asynchronous reset between clock edges.
        run_i = 1'b1;
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("t6Rgb",    {red_o, green_o, blue_o}, 32'h0);
        checkOutput("t6Blank",  blankN_o, 32'd0);
        checkOutput("t6BoxX",   boxX_o, 32'd0);
        checkOutput("t6BoxY",   boxY_o, 32'd0);
        checkOutput("t6Frames", frameCount_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        frameTicks(1);
        checkOutput("t6TickX",   boxX_o, 32'd2);
        checkOutput("t6TickF",   frameCount_o, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
